// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: widths, IR field
// positions, opcode constants, state encoding and the registered strobe bundle.
// Optional feature macro: SINGLE_STEP_EN (adds the STEP_WAIT state).
package cpu_ctrl_pkg;

    localparam int OPW = 5;   // opcode width
    localparam int RW  = 4;   // register-field width
    localparam int DW  = 32;  // IR width

    // IR field bit positions
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    // Opcodes understood by the sequencer; everything else executes as a NOP
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b01001;
    localparam logic [OPW-1:0] OP_OR   = 5'b01010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_T0        = 4'd1,
        S_T1        = 4'd2,
        S_T2        = 4'd3,
        S_T3        = 4'd4,
        S_T4        = 4'd5,
        S_T5        = 4'd6,
        S_HALT      = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 4'd8
`endif
    } state_t;

    // Every datapath strobe, registered together so all of them change on the
    // same edge as the state register.
    typedef struct packed {
        logic           pc_out;
        logic           zlow_out;
        logic           mdr_out;
        logic           mar_in;
        logic           z_in;
        logic           pc_in;
        logic           mdr_in;
        logic           ir_in;
        logic           y_in;
        logic           inc_pc;
        logic           read;
        logic           rout;
        logic           rin;
        logic           halt;
        logic           busy;
        logic [RW-1:0]  rout_sel;
        logic [RW-1:0]  rin_sel;
        logic [OPW-1:0] alu_op;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath. The sequencer is the
// master (drives strobes, reads ir/mem_done/run); the datapath side is the slave.
// Optional feature macro: SINGLE_STEP_EN (adds the step input).
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic           run;
    logic [DW-1:0]  ir;
    logic           mem_done;
`ifdef SINGLE_STEP_EN
    logic           step;
`endif

    logic           pc_out;
    logic           zlow_out;
    logic           mdr_out;
    logic           mar_in;
    logic           z_in;
    logic           pc_in;
    logic           mdr_in;
    logic           ir_in;
    logic           y_in;
    logic           inc_pc;
    logic           read;
    logic           rout;
    logic [RW-1:0]  rout_sel;
    logic           rin;
    logic [RW-1:0]  rin_sel;
    logic [OPW-1:0] alu_op;
    logic           halt;
    logic           busy;

    modport master (
        input  run, ir, mem_done,
`ifdef SINGLE_STEP_EN
        input  step,
`endif
        output pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in,
               y_in, inc_pc, read, rout, rout_sel, rin, rin_sel, alu_op,
               halt, busy
    );

    modport slave (
        output run, ir, mem_done,
`ifdef SINGLE_STEP_EN
        output step,
`endif
        input  pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in,
               y_in, inc_pc, read, rout, rout_sel, rin, rin_sel, alu_op,
               halt, busy
    );

endinterface

// File: rtl/ir_field_decode.sv
// Combinational split of the instruction register into opcode and the three
// register fields, plus a flag for the three-register ALU opcodes.
module ir_field_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [DW-1:0]  ir,
    output logic [OPW-1:0] op,
    output logic [RW-1:0]  ra,
    output logic [RW-1:0]  rb,
    output logic [RW-1:0]  rc,
    output logic           is_alu
);

    // Low IR bits carry immediates for other instruction classes; not used here.
    logic unused_low_bits;

    assign op              = ir[OP_MSB:OP_LSB];
    assign ra              = ir[RA_MSB:RA_LSB];
    assign rb              = ir[RB_MSB:RB_LSB];
    assign rc              = ir[RC_MSB:RC_LSB];
    assign is_alu          = is_alu_op(op);
    assign unused_low_bits = ^ir[RC_LSB-1:0];

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) and execute (T3-T5) of three-register
// ALU instructions, with a memory-done stall in T1. All strobes are registered
// Moore outputs decoded from the next state.
// Optional feature macro: SINGLE_STEP_EN (step input, STEP_WAIT state between
// instructions, left on a rising edge of step).
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    control_sequencer_if.master bus
);

    logic [OPW-1:0] op;
    logic [RW-1:0]  ra;
    logic [RW-1:0]  rb;
    logic [RW-1:0]  rc;
    logic           is_alu;

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl_reg;
    ctrl_t  ctrl_next;
    logic   step_rise;

`ifdef SINGLE_STEP_EN
    localparam state_t RESUME_STATE = S_STEP_WAIT;
    logic step_prev_reg;
    assign step_rise = bus.step & ~step_prev_reg;
`else
    localparam state_t RESUME_STATE = S_T0;
    assign step_rise = 1'b0;
`endif

    ir_field_decode u_decode (
        .ir     (bus.ir),
        .op     (op),
        .ra     (ra),
        .rb     (rb),
        .rc     (rc),
        .is_alu (is_alu)
    );

    // Next-state logic; run only matters in IDLE, T5, the NOP exit of T3 and STEP_WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.run) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (bus.mem_done) state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3: begin
                if (is_alu)              state_next = S_T4;
                else if (op == OP_HALT)  state_next = S_HALT;
                else if (bus.run)        state_next = RESUME_STATE;
                else                     state_next = S_IDLE;
            end
            S_T4:   state_next = S_T5;
            S_T5:   state_next = bus.run ? RESUME_STATE : S_IDLE;
            S_HALT: state_next = S_HALT;
`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (!bus.run)       state_next = S_IDLE;
                else if (step_rise) state_next = S_T0;
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Strobe decode for the state about to be entered. The T3 select uses ir as
    // presented on the T2->T3 edge, so the datapath must show the fetched word
    // on ir by then; T4/T5 fields are taken while the IR is stable.
    always_comb begin
        ctrl_next = '0;
        case (state_next)
            S_T0: begin
                ctrl_next.pc_out = 1'b1;
                ctrl_next.mar_in = 1'b1;
                ctrl_next.inc_pc = 1'b1;
                ctrl_next.z_in   = 1'b1;
                ctrl_next.busy   = 1'b1;
            end
            S_T1: begin
                ctrl_next.read   = 1'b1;
                ctrl_next.mdr_in = 1'b1;
                ctrl_next.busy   = 1'b1;
                // PC reload only once, on the cycle T1 is entered from T0
                if (state_reg == S_T0) begin
                    ctrl_next.pc_in    = 1'b1;
                    ctrl_next.zlow_out = 1'b1;
                end
            end
            S_T2: begin
                ctrl_next.mdr_out = 1'b1;
                ctrl_next.ir_in   = 1'b1;
                ctrl_next.busy    = 1'b1;
            end
            S_T3: begin
                ctrl_next.busy = 1'b1;
                if (is_alu) begin
                    ctrl_next.rout     = 1'b1;
                    ctrl_next.rout_sel = rb;
                    ctrl_next.y_in     = 1'b1;
                end
            end
            S_T4: begin
                ctrl_next.rout     = 1'b1;
                ctrl_next.rout_sel = rc;
                ctrl_next.alu_op   = op;
                ctrl_next.z_in     = 1'b1;
                ctrl_next.busy     = 1'b1;
            end
            S_T5: begin
                ctrl_next.zlow_out = 1'b1;
                ctrl_next.rin      = 1'b1;
                ctrl_next.rin_sel  = ra;
                ctrl_next.busy     = 1'b1;
            end
            S_HALT: ctrl_next.halt = 1'b1;
            default: ctrl_next = '0;
        endcase
    end

    // State, strobe and step-history registers; reset clears every strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            ctrl_reg  <= '0;
`ifdef SINGLE_STEP_EN
            step_prev_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            ctrl_reg  <= ctrl_next;
`ifdef SINGLE_STEP_EN
            step_prev_reg <= bus.step;
`endif
        end
    end

    assign bus.pc_out   = ctrl_reg.pc_out;
    assign bus.zlow_out = ctrl_reg.zlow_out;
    assign bus.mdr_out  = ctrl_reg.mdr_out;
    assign bus.mar_in   = ctrl_reg.mar_in;
    assign bus.z_in     = ctrl_reg.z_in;
    assign bus.pc_in    = ctrl_reg.pc_in;
    assign bus.mdr_in   = ctrl_reg.mdr_in;
    assign bus.ir_in    = ctrl_reg.ir_in;
    assign bus.y_in     = ctrl_reg.y_in;
    assign bus.inc_pc   = ctrl_reg.inc_pc;
    assign bus.read     = ctrl_reg.read;
    assign bus.rout     = ctrl_reg.rout;
    assign bus.rout_sel = ctrl_reg.rout_sel;
    assign bus.rin      = ctrl_reg.rin;
    assign bus.rin_sel  = ctrl_reg.rin_sel;
    assign bus.alu_op   = ctrl_reg.alu_op;
    assign bus.halt     = ctrl_reg.halt;
    assign bus.busy     = ctrl_reg.busy;

endmodule
